// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller.
package mem_access_ctrl_pkg;

  localparam logic True_v  = 1'b1;
  localparam logic False_v = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } mac_state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: req/ack bus handshake, pipeline stall,
// misalignment and bus-timeout write-back suppression.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [31:0] MEM_Addr,
  input  logic [31:0] MEM_WriteData,
  output logic        Bus_Req,
  output logic        Bus_We,
  output logic [31:0] Bus_Addr,
  output logic [31:0] Bus_WData,
  input  logic        Bus_Ack,
  input  logic [31:0] Bus_RData,
  output logic        Stall_Req,
  output logic [31:0] MEM_ReadMemData,
  output logic        MEM_Kill,
  output logic        Align_Err,
  output logic        Bus_Err
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  mac_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_d, we_d, err_d;
  logic [31:0]      addr_d, wdata_d, rdata_d;
  logic             acc, mis;

  assign acc = MEM_MemRead | MEM_MemWrite;
  assign mis = acc & (MEM_Addr[1:0] != 2'b00);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      Bus_Req         <= False_v;
      Bus_We          <= False_v;
      Bus_Addr        <= '0;
      Bus_WData       <= '0;
      MEM_ReadMemData <= '0;
      Bus_Err         <= False_v;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      Bus_Req         <= req_d;
      Bus_We          <= we_d;
      Bus_Addr        <= addr_d;
      Bus_WData       <= wdata_d;
      MEM_ReadMemData <= rdata_d;
      Bus_Err         <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = Bus_Req;
    we_d      = Bus_We;
    addr_d    = Bus_Addr;
    wdata_d   = Bus_WData;
    rdata_d   = MEM_ReadMemData;
    err_d     = False_v;
    Stall_Req = False_v;
    MEM_Kill  = False_v;
    Align_Err = False_v;
    unique case (state_q)
      IDLE: begin
        if (mis) begin
          Align_Err = True_v;
          MEM_Kill  = True_v;
        end else if (acc) begin
          state_d   = REQ;
          Stall_Req = True_v;
          req_d     = True_v;
          we_d      = MEM_MemWrite;
          addr_d    = {MEM_Addr[31:2], 2'b00};
          wdata_d   = MEM_WriteData;
          cnt_d     = '0;
        end
      end
      REQ: begin
        Stall_Req = True_v;
        // An ack on the final timeout cycle takes priority over the abort.
        if (Bus_Ack) begin
          state_d = DONE;
          req_d   = False_v;
          if (!Bus_We) rdata_d = Bus_RData;
        end else if (cnt_q == TO_LAST) begin
          state_d = ERR;
          req_d   = False_v;
          err_d   = True_v;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      ERR: begin
        MEM_Kill = True_v;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: per-access expectations are queued
// when an instruction is presented and compared when it leaves MEM.
module tb_mem_access_ctrl;

  localparam int TO = 16;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        MEM_MemRead = 1'b0, MEM_MemWrite = 1'b0;
  logic [31:0] MEM_Addr = '0, MEM_WriteData = '0;
  logic        Bus_Req, Bus_We;
  logic [31:0] Bus_Addr, Bus_WData;
  logic        Bus_Ack = 1'b0;
  logic [31:0] Bus_RData = '0;
  logic        Stall_Req;
  logic [31:0] MEM_ReadMemData;
  logic        MEM_Kill, Align_Err, Bus_Err;

  mem_access_ctrl #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .Clk(Clk), .Rst(Rst),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .MEM_Addr(MEM_Addr), .MEM_WriteData(MEM_WriteData),
    .Bus_Req(Bus_Req), .Bus_We(Bus_We), .Bus_Addr(Bus_Addr), .Bus_WData(Bus_WData),
    .Bus_Ack(Bus_Ack), .Bus_RData(Bus_RData),
    .Stall_Req(Stall_Req), .MEM_ReadMemData(MEM_ReadMemData),
    .MEM_Kill(MEM_Kill), .Align_Err(Align_Err), .Bus_Err(Bus_Err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] addr, wdata, rdata;
    logic        we, kill, align, berr;
    int          stalls, reqs;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_rdata = '0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ack_at: index of the REQ cycle on which memory acks, -1 for never.
  task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int ack_at);
    exp_t e, g;
    int   req_n, stalls;
    bit   left;
    e.addr  = {addr[31:2], 2'b00};
    e.wdata = wdata;
    e.we    = wr;
    e.align = 1'b0; e.kill = 1'b0; e.berr = 1'b0;
    if (addr[1:0] != 2'b00) begin
      e.align = 1'b1; e.kill = 1'b1; e.stalls = 0; e.reqs = 0;
    end else if (ack_at >= 0 && ack_at < TO) begin
      e.stalls = ack_at + 2; e.reqs = ack_at + 1;
      if (rd && !wr) model_rdata = rdata;
    end else begin
      e.kill = 1'b1; e.berr = 1'b1; e.stalls = TO + 1; e.reqs = TO;
    end
    e.rdata = model_rdata;
    sb.push_back(e);

    @(negedge Clk);
    MEM_MemRead = rd; MEM_MemWrite = wr; MEM_Addr = addr; MEM_WriteData = wdata;
    req_n = 0; stalls = 0; left = 0;
    g = e;
    for (int c = 0; c < TO + 8; c++) begin
      if (c > 0) @(negedge Clk);
      Bus_Ack = 1'b0;
      if (Bus_Req) begin
        if (req_n == 0) begin g.addr = Bus_Addr; g.wdata = Bus_WData; g.we = Bus_We; end
        if (req_n == ack_at) begin Bus_Ack = 1'b1; Bus_RData = rdata; end
        req_n++;
      end
      #1;
      if (Stall_Req) stalls++;
      else begin
        g.kill = MEM_Kill; g.align = Align_Err; g.berr = Bus_Err; g.rdata = MEM_ReadMemData;
        left = 1;
        break;
      end
    end
    check_eq("left_mem_in_budget", 32'(left), 32'd1);

    e = sb.pop_front();
    check_eq("stall_cycles", 32'(stalls), 32'(e.stalls));
    check_eq("req_cycles", 32'(req_n), 32'(e.reqs));
    if (e.reqs > 0) begin
      check_eq("bus_addr", g.addr, e.addr);
      check_eq("bus_we", 32'(g.we), 32'(e.we));
      if (e.we) check_eq("bus_wdata", g.wdata, e.wdata);
    end
    check_eq("kill", 32'(g.kill), 32'(e.kill));
    check_eq("align_err", 32'(g.align), 32'(e.align));
    check_eq("bus_err", 32'(g.berr), 32'(e.berr));
    check_eq("read_data", g.rdata, e.rdata);

    // Instruction has left MEM: one-cycle flags must be gone, controller idle.
    @(negedge Clk);
    Bus_Ack = 1'b0; MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0;
    #1;
    check_eq("post_idle", {28'd0, Bus_Req, Stall_Req, MEM_Kill | Align_Err, Bus_Err}, 32'd0);
  endtask

  initial begin
    #12;
    check_eq("rst_ctrl", {26'd0, Bus_Req, Bus_We, Bus_Err, Stall_Req, MEM_Kill, Align_Err}, 32'd0);
    check_eq("rst_addr", Bus_Addr, 32'd0);
    check_eq("rst_wdata", Bus_WData, 32'd0);
    check_eq("rst_rdata", MEM_ReadMemData, 32'd0);
    @(negedge Clk); Rst = 1'b1;

    run_op(1, 0, 32'h0000_0100, 32'h0,           32'hDEAD_BEEF, 0);
    run_op(0, 1, 32'h0000_0204, 32'h1234_5678,   32'h5555_5555, 3);
    run_op(1, 0, 32'h0000_0103, 32'h0,           32'h0,         0);
    run_op(1, 0, 32'h0000_0300, 32'h0,           32'h0BAD_0BAD, -1);
    run_op(1, 0, 32'h0000_0400, 32'h0,           32'hCAFE_F00D, TO - 1);
    run_op(0, 1, 32'h0000_0206, 32'hAAAA_AAAA,   32'h0,         0);
    run_op(0, 1, 32'h0000_0500, 32'h0F0F_0F0F,   32'h0,         -1);

    // Ack while idle must be ignored.
    @(negedge Clk); Bus_Ack = 1'b1; Bus_RData = 32'h1111_2222;
    @(negedge Clk); Bus_Ack = 1'b0; #1;
    check_eq("idle_ack_req", 32'(Bus_Req), 32'd0);
    check_eq("idle_ack_data", MEM_ReadMemData, model_rdata);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      int          k;
      a = $urandom & 32'h0000_FFFF;
      if (($urandom % 4) != 0) a[1:0] = 2'b00;
      k = ($urandom % 6 == 0) ? -1 : int'($urandom_range(0, 5));
      run_op(i[0], !i[0], a, $urandom, $urandom, k);
    end

    // Asynchronous reset between edges in the middle of a request.
    @(negedge Clk);
    MEM_MemRead = 1'b1; MEM_Addr = 32'h0000_0600;
    repeat (3) @(negedge Clk);
    #1;
    check_eq("pre_rst_req", 32'(Bus_Req), 32'd1);
    #1; Rst = 1'b0; MEM_MemRead = 1'b0; #1;
    check_eq("async_rst_req", 32'(Bus_Req), 32'd0);
    check_eq("async_rst_stall", 32'(Stall_Req), 32'd0);
    check_eq("async_rst_rdata", MEM_ReadMemData, 32'd0);
    model_rdata = '0;
    @(negedge Clk); Rst = 1'b1;
    run_op(1, 0, 32'h0000_0700, 32'h0, 32'h7777_1234, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
